// File: rtl/exmem_stage_reg_if.sv
// ---------------------------------------------------------------------------
// exmem_stage_reg_if
// Groups the EX->MEM pipeline handshake and payload signals.
//
// EX side : ex_valid, ex_ready, ex_alu, ex_dselect, ex_store_data, ex_ctrl
// MEM side: mem_valid, mem_ready, mem_dbus, mem_dselect, mem_store_data,
//           mem_ctrl
// Status  : occupancy (number of entries held by the stage register, 0..2)
//
// Modports:
//   master - the surrounding pipeline (drives EX payload and mem_ready)
//   slave  - the stage register itself
// ---------------------------------------------------------------------------
interface exmem_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 32,
    parameter int CTRL_W = 2
);
    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] ex_alu;
    logic [SEL_W-1:0]  ex_dselect;
    logic [DATA_W-1:0] ex_store_data;
    logic [CTRL_W-1:0] ex_ctrl;

    logic              mem_valid;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_dbus;
    logic [SEL_W-1:0]  mem_dselect;
    logic [DATA_W-1:0] mem_store_data;
    logic [CTRL_W-1:0] mem_ctrl;

    logic [1:0]        occupancy;

    modport master (
        output ex_valid, ex_alu, ex_dselect, ex_store_data, ex_ctrl, mem_ready,
        input  ex_ready, mem_valid, mem_dbus, mem_dselect, mem_store_data,
               mem_ctrl, occupancy
    );

    modport slave (
        input  ex_valid, ex_alu, ex_dselect, ex_store_data, ex_ctrl, mem_ready,
        output ex_ready, mem_valid, mem_dbus, mem_dselect, mem_store_data,
               mem_ctrl, occupancy
    );
endinterface

// File: rtl/exmem_stage_reg.sv
// ---------------------------------------------------------------------------
// exmem_stage_reg
// EX/MEM pipeline register built as a two-entry skid buffer. The main entry
// drives the MEM-side outputs; the skid entry catches the instruction that
// arrives in the cycle MEM stalls, so ex_ready depends only on registered
// state and never on mem_ready.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (clears both entries and payloads)
//   flush  - discards all held and same-cycle incoming instructions
//   bus    - exmem_stage_reg_if.slave: EX handshake/payload in, MEM
//            handshake/payload out, occupancy
// ---------------------------------------------------------------------------
module exmem_stage_reg #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 32,
    parameter int CTRL_W = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    exmem_stage_reg_if.slave        bus
);

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [SEL_W-1:0]  dselect;
        logic [DATA_W-1:0] store_data;
        logic [CTRL_W-1:0] ctrl;
    } payload_t;

    logic     m_valid;
    logic     s_valid;
    payload_t m_data;
    payload_t s_data;
    payload_t in_data;
    logic     accept;
    logic     consume;

    assign in_data = '{alu:        bus.ex_alu,
                       dselect:    bus.ex_dselect,
                       store_data: bus.ex_store_data,
                       ctrl:       bus.ex_ctrl};

    // Ready is purely a function of the skid entry so mem_ready never
    // reaches ex_ready combinationally.
    assign bus.ex_ready = ~s_valid;
    assign accept       = bus.ex_valid & ~s_valid;
    assign consume      = m_valid & bus.mem_ready;

    // Main/skid update. The skid entry is only ever filled while main is
    // full and stalled, so skid-valid with main-empty cannot occur, and
    // when the skid drains into main no new instruction can be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_data  <= '0;
            s_data  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (s_valid) begin
            if (consume) begin
                m_data  <= s_data;
                s_valid <= 1'b0;
            end
        end else if (m_valid) begin
            if (consume) begin
                if (accept) begin
                    m_data <= in_data;
                end else begin
                    m_valid <= 1'b0;
                end
            end else if (accept) begin
                s_data  <= in_data;
                s_valid <= 1'b1;
            end
        end else if (accept) begin
            m_data  <= in_data;
            m_valid <= 1'b1;
        end
    end

    assign bus.mem_valid      = m_valid;
    assign bus.mem_dbus       = m_data.alu;
    assign bus.mem_dselect    = m_data.dselect;
    assign bus.mem_store_data = m_data.store_data;
    // Gate the control bits so a stale LW/SW never leaks out of an empty entry.
    assign bus.mem_ctrl       = m_data.ctrl & {CTRL_W{m_valid}};
    assign bus.occupancy      = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_exmem_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_exmem_stage_reg
// Self-checking bench for exmem_stage_reg. A FIFO-queue reference model of
// capacity two predicts the MEM-side view after every clock edge; directed
// scenarios cover single transfer, backpressure, full throughput, flush and
// asynchronous reset, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_exmem_stage_reg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 32;
    localparam int CTRL_W = 2;

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [SEL_W-1:0]  dselect;
        logic [DATA_W-1:0] store_data;
        logic [CTRL_W-1:0] ctrl;
    } payload_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    exmem_stage_reg_if #(.DATA_W(DATA_W), .SEL_W(SEL_W), .CTRL_W(CTRL_W)) bus ();

    exmem_stage_reg #(.DATA_W(DATA_W), .SEL_W(SEL_W), .CTRL_W(CTRL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    // 10-unit clock; rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Reference model: the instructions held by the stage, oldest first.
    payload_t modelQ[$];
    int checkCount = 0;
    int passCount  = 0;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // Compare the DUT against what the queue model says MEM should see.
    task automatic compareModel(input string tag);
        payload_t head;
        checkOutput({tag, ".mem_valid"}, 64'(bus.mem_valid), 64'(modelQ.size() > 0));
        checkOutput({tag, ".ex_ready"},  64'(bus.ex_ready),  64'(modelQ.size() < 2));
        checkOutput({tag, ".occupancy"}, 64'(bus.occupancy), 64'(modelQ.size()));
        if (modelQ.size() > 0) begin
            head = modelQ[0];
            checkOutput({tag, ".mem_dbus"},       64'(bus.mem_dbus),       64'(head.alu));
            checkOutput({tag, ".mem_dselect"},    64'(bus.mem_dselect),    64'(head.dselect));
            checkOutput({tag, ".mem_store_data"}, 64'(bus.mem_store_data), 64'(head.store_data));
            checkOutput({tag, ".mem_ctrl"},       64'(bus.mem_ctrl),       64'(head.ctrl));
        end else begin
            checkOutput({tag, ".mem_ctrl_idle"},  64'(bus.mem_ctrl),       64'(0));
        end
    endtask

    // All outputs must read their reset values.
    task automatic checkResetState(input string tag);
        checkOutput({tag, ".mem_valid"},      64'(bus.mem_valid),      64'(0));
        checkOutput({tag, ".mem_dbus"},       64'(bus.mem_dbus),       64'(0));
        checkOutput({tag, ".mem_dselect"},    64'(bus.mem_dselect),    64'(0));
        checkOutput({tag, ".mem_store_data"}, 64'(bus.mem_store_data), 64'(0));
        checkOutput({tag, ".mem_ctrl"},       64'(bus.mem_ctrl),       64'(0));
        checkOutput({tag, ".occupancy"},      64'(bus.occupancy),      64'(0));
        checkOutput({tag, ".ex_ready"},       64'(bus.ex_ready),       64'(1));
    endtask

    function automatic payload_t makePayload(input logic [31:0] alu, input logic [1:0] ctrl);
        payload_t p;
        p.alu        = alu;
        p.dselect    = 32'h1 << $urandom_range(0, 31);
        p.store_data = $urandom;
        p.ctrl       = ctrl;
        return p;
    endfunction

    // Drive one cycle of inputs (called at a negedge), advance the model
    // across the rising edge, then compare at the following negedge.
    task automatic applyStimulus(input logic valid, input payload_t p,
                                 input logic ready, input logic fl, input string tag);
        bit doAccept;
        bit doConsume;
        bus.ex_valid      = valid;
        bus.ex_alu        = p.alu;
        bus.ex_dselect    = p.dselect;
        bus.ex_store_data = p.store_data;
        bus.ex_ctrl       = p.ctrl;
        bus.mem_ready     = ready;
        flush             = fl;
        doAccept  = valid && (modelQ.size() < 2);
        doConsume = ready && (modelQ.size() > 0);
        @(posedge clk);
        if (fl) begin
            modelQ.delete();
        end else begin
            if (doConsume) void'(modelQ.pop_front());
            if (doAccept) modelQ.push_back(p);
        end
        @(negedge clk);
        compareModel(tag);
    endtask

    initial begin
        payload_t p;
        int maxOcc;
        bus.ex_valid      = 1'b0;
        bus.ex_alu        = '0;
        bus.ex_dselect    = '0;
        bus.ex_store_data = '0;
        bus.ex_ctrl       = '0;
        bus.mem_ready     = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkResetState("reset");
        rst_n = 1'b1;
        @(negedge clk);
        compareModel("post_reset");

        // Single transfer
        applyStimulus(1'b1, makePayload(32'h1234, 2'b01), 1'b1, 1'b0, "single_accept");
        checkOutput("single.dbus", 64'(bus.mem_dbus), 64'h1234);
        checkOutput("single.ctrl", 64'(bus.mem_ctrl), 64'h1);
        applyStimulus(1'b0, makePayload(32'h0, 2'b00), 1'b1, 1'b0, "single_drain");
        checkOutput("single.valid_after", 64'(bus.mem_valid), 64'h0);
        checkOutput("single.ctrl_after",  64'(bus.mem_ctrl),  64'h0);

        // Backpressure: A then B with MEM stalled
        applyStimulus(1'b1, makePayload(32'h10, 2'b10), 1'b0, 1'b0, "bp_a");
        applyStimulus(1'b1, makePayload(32'h20, 2'b01), 1'b0, 1'b0, "bp_b");
        checkOutput("bp.occupancy", 64'(bus.occupancy), 64'h2);
        checkOutput("bp.ex_ready",  64'(bus.ex_ready),  64'h0);
        checkOutput("bp.dbus_hold", 64'(bus.mem_dbus),  64'h10);
        applyStimulus(1'b1, makePayload(32'h30, 2'b01), 1'b0, 1'b0, "bp_stall");
        checkOutput("bp.dbus_stall", 64'(bus.mem_dbus), 64'h10);
        applyStimulus(1'b0, makePayload(32'h0, 2'b00), 1'b1, 1'b0, "bp_release1");
        checkOutput("bp.dbus_second", 64'(bus.mem_dbus), 64'h20);
        applyStimulus(1'b0, makePayload(32'h0, 2'b00), 1'b1, 1'b0, "bp_release2");
        checkOutput("bp.drained", 64'(bus.mem_valid), 64'h0);

        // Full throughput
        maxOcc = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, makePayload(32'(i), 2'b01), 1'b1, 1'b0, "stream");
            checkOutput("stream.dbus", 64'(bus.mem_dbus), 64'(i));
            if (int'(bus.occupancy) > maxOcc) maxOcc = int'(bus.occupancy);
        end
        checkOutput("stream.max_occ_le1", 64'(maxOcc <= 1), 64'h1);
        applyStimulus(1'b0, makePayload(32'h0, 2'b00), 1'b1, 1'b0, "stream_drain");

        // Flush with two held entries and an incoming instruction
        applyStimulus(1'b1, makePayload(32'h40, 2'b10), 1'b0, 1'b0, "fl_a");
        applyStimulus(1'b1, makePayload(32'h50, 2'b01), 1'b0, 1'b0, "fl_b");
        applyStimulus(1'b1, makePayload(32'h60, 2'b11), 1'b1, 1'b1, "flush2");
        checkOutput("flush.valid",     64'(bus.mem_valid), 64'h0);
        checkOutput("flush.ctrl",      64'(bus.mem_ctrl),  64'h0);
        checkOutput("flush.occupancy", 64'(bus.occupancy), 64'h0);
        checkOutput("flush.ex_ready",  64'(bus.ex_ready),  64'h1);
        // Flush with one held entry and an accept that would otherwise succeed
        applyStimulus(1'b1, makePayload(32'h70, 2'b01), 1'b0, 1'b0, "fl_c");
        applyStimulus(1'b1, makePayload(32'h80, 2'b10), 1'b0, 1'b1, "flush1");
        checkOutput("flush1.occupancy", 64'(bus.occupancy), 64'h0);

        // Asynchronous reset between edges while two entries are held
        applyStimulus(1'b1, makePayload(32'h90, 2'b10), 1'b0, 1'b0, "ar_a");
        applyStimulus(1'b1, makePayload(32'hA0, 2'b01), 1'b0, 1'b0, "ar_b");
        checkOutput("ar.occupancy_before", 64'(bus.occupancy), 64'h2);
        #2 rst_n = 1'b0;
        #1 checkResetState("async_reset");
        modelQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, makePayload(32'hB0, 2'b01), 1'b1, 1'b0, "after_reset");
        checkOutput("after_reset.dbus", 64'(bus.mem_dbus), 64'hB0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            p = makePayload($urandom, 2'($urandom_range(0, 3)));
            applyStimulus(1'($urandom_range(0, 1)), p,
                          ($urandom_range(0, 9) < 6), ($urandom_range(0, 24) == 0),
                          "random");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
